// File: rtl/keyq_pkg.sv
// Shared types and constants for the key event queue: key codes and small
// combinational helpers used by the arbitration logic.
package keyq_pkg;

   localparam int KEY_CODE_W = 3;
   localparam int NUM_KEYS   = 5;

   typedef logic [KEY_CODE_W-1:0] ev_code_t;

   localparam ev_code_t KEY_0 = 3'd0;
   localparam ev_code_t KEY_1 = 3'd1;
   localparam ev_code_t KEY_2 = 3'd2;
   localparam ev_code_t KEY_3 = 3'd3;
   localparam ev_code_t KEY_4 = 3'd4;

   // Index of the lowest set bit; KEY_0 when no bit is set.
   function automatic ev_code_t first_key(input logic [NUM_KEYS-1:0] v);
      ev_code_t c;
      c = KEY_0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (v[i]) begin
            c = ev_code_t'(i);
         end else begin
            c = c;
         end
      end
      return c;
   endfunction

   function automatic logic [KEY_CODE_W-1:0] count_ones(input logic [NUM_KEYS-1:0] v);
      logic [KEY_CODE_W-1:0] n;
      n = 3'd0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         n = n + {2'b00, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/keyq_fifo.sv
// Show-ahead synchronous FIFO of key codes; full/empty come from the
// occupancy counter, pointers simply wrap.
module keyq_fifo
   import keyq_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  ev_code_t              push_data,
   input  logic                  pop,
   output logic                  valid,
   output ev_code_t              rd_data,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] ZERO_CNT = {(AW+1){1'b0}};

   ev_code_t        mem_q [DEPTH];
   ev_code_t        mem_d [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     count_q, count_d;
   logic            do_push_s, do_pop_s;

   // Next-state for storage, pointers and occupancy.
   always_comb begin
      do_pop_s  = pop && (count_q != ZERO_CNT);
      do_push_s = push && ((count_q < FULL_CNT) || do_pop_s);
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      if (do_push_s) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= KEY_0;
         end
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         count_q  <= ZERO_CNT;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign valid   = (count_q != ZERO_CNT);
   assign rd_data = valid ? mem_q[rd_ptr_q] : KEY_0;
   assign count   = count_q;

endmodule

// File: rtl/key_event_queue.sv
// Turns debounced key pulses into an ordered stream of key codes with
// per-key pending presses and sticky loss flag. KEYQ_DROP_CNT_EN adds drop_cnt.
module key_event_queue #(
   parameter int DEPTH    = 8,
   parameter int NUM_KEYS = 5
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_KEYS-1:0]      key_pulse,
   output logic                     ev_valid,
   output keyq_pkg::ev_code_t       ev_code,
   input  logic                     ev_ready,
   output logic [$clog2(DEPTH):0]   ev_count,
   output logic                     ovf,
   input  logic                     ovf_clr
`ifdef KEYQ_DROP_CNT_EN
   ,
   output logic [7:0]               drop_cnt
`endif
);

   import keyq_pkg::*;

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [NUM_KEYS-1:0] pend_q, pend_d;
   logic [NUM_KEYS-1:0] req_s, grant_s, drop_s;
   logic                ovf_q, ovf_d;
   logic                pop_s, push_ok_s, push_s, fifo_valid_s;
   ev_code_t            push_code_s;
   logic [CW-1:0]       count_s;

   // Priority grant, pending bookkeeping and loss detection.
   always_comb begin
      req_s     = pend_q | key_pulse;
      pop_s     = fifo_valid_s & ev_ready;
      push_ok_s = (count_s < FULL_CNT) | pop_s;
      if (push_ok_s) begin
         grant_s = req_s & (~req_s + NUM_KEYS'(1));
      end else begin
         grant_s = {NUM_KEYS{1'b0}};
      end
      push_s      = |grant_s;
      push_code_s = first_key(req_s);
      pend_d      = req_s & ~grant_s;
      drop_s      = key_pulse & pend_q & ~grant_s;
      // A drop in the same cycle as a clear keeps the flag set.
      if (|drop_s) begin
         ovf_d = 1'b1;
      end else if (ovf_clr) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
   end

   // Pending presses and sticky overflow flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pend_q <= {NUM_KEYS{1'b0}};
         ovf_q  <= 1'b0;
      end else begin
         pend_q <= pend_d;
         ovf_q  <= ovf_d;
      end
   end

`ifdef KEYQ_DROP_CNT_EN
   logic [7:0] drop_cnt_q, drop_cnt_d;
   logic [8:0] drop_sum_s;

   // Saturating lost-press counter; only reset clears it.
   always_comb begin
      drop_sum_s = {1'b0, drop_cnt_q} + {6'd0, count_ones(drop_s)};
      if (drop_sum_s > 9'd255) begin
         drop_cnt_d = 8'd255;
      end else begin
         drop_cnt_d = drop_sum_s[7:0];
      end
   end

   // Drop counter register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         drop_cnt_q <= 8'd0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign drop_cnt = drop_cnt_q;
`endif

   keyq_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_s),
      .push_data (push_code_s),
      .pop       (pop_s),
      .valid     (fifo_valid_s),
      .rd_data   (ev_code),
      .count     (count_s)
   );

   assign ev_valid = fifo_valid_s;
   assign ev_count = count_s;
   assign ovf      = ovf_q;

endmodule

// File: tb/tb_key_event_queue.sv
// Directed scoreboard bench for key_event_queue (DEPTH=8).
module tb_key_event_queue;

   logic       clk;
   logic       rst_n;
   logic [4:0] key_pulse;
   logic       ev_valid;
   logic [2:0] ev_code;
   logic       ev_ready;
   logic [3:0] ev_count;
   logic       ovf;
   logic       ovf_clr;
`ifdef KEYQ_DROP_CNT_EN
   logic [7:0] drop_cnt;
`endif

   int         chk_cnt  = 0;
   int         pass_cnt = 0;
   int         exp_q[$];

   key_event_queue #(.DEPTH(8), .NUM_KEYS(5)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_pulse (key_pulse),
      .ev_valid  (ev_valid),
      .ev_code   (ev_code),
      .ev_ready  (ev_ready),
      .ev_count  (ev_count),
      .ovf       (ovf),
      .ovf_clr   (ovf_clr)
`ifdef KEYQ_DROP_CNT_EN
      ,
      .drop_cnt  (drop_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_drop(input logic [7:0] exp);
`ifdef KEYQ_DROP_CNT_EN
      chk("drop_cnt", {24'd0, drop_cnt}, {24'd0, exp});
`endif
   endtask

   // Pop the head (optionally with pulses in the same cycle) and score it.
   task automatic pop_one(input logic [4:0] pulse);
      int e;
      chk("sb_nonempty", {31'd0, exp_q.size() > 0}, 32'd1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      chk("pop_valid", {31'd0, ev_valid}, 32'd1);
      chk("pop_code", {29'd0, ev_code}, e);
      ev_ready  = 1'b1;
      key_pulse = pulse;
      cyc();
      ev_ready  = 1'b0;
      key_pulse = 5'b00000;
   endtask

   task automatic chk_reset_state();
      chk("rst_valid", {31'd0, ev_valid}, 32'd0);
      chk("rst_code", {29'd0, ev_code}, 32'd0);
      chk("rst_count", {28'd0, ev_count}, 32'd0);
      chk("rst_ovf", {31'd0, ovf}, 32'd0);
      chk("rst_pend", {27'd0, dut.pend_q}, 32'd0);
      chk("rst_wptr", {29'd0, dut.u_fifo.wr_ptr_q}, 32'd0);
      chk("rst_rptr", {29'd0, dut.u_fifo.rd_ptr_q}, 32'd0);
      chk_drop(8'd0);
   endtask

   task automatic single_press_scenario();
      key_pulse = 5'b00100;
      exp_q.push_back(2);
      cyc();
      key_pulse = 5'b00000;
      chk("s1_valid", {31'd0, ev_valid}, 32'd1);
      chk("s1_code", {29'd0, ev_code}, 32'd2);
      chk("s1_count", {28'd0, ev_count}, 32'd1);
      pop_one(5'b00000);
      chk("s1_empty_valid", {31'd0, ev_valid}, 32'd0);
      chk("s1_empty_count", {28'd0, ev_count}, 32'd0);
      chk("s1_empty_code", {29'd0, ev_code}, 32'd0);
   endtask

   initial begin
      int seq [8] = '{0, 1, 2, 4, 0, 1, 2, 4};
      rst_n     = 1'b0;
      key_pulse = 5'b00000;
      ev_ready  = 1'b0;
      ovf_clr   = 1'b0;
      cyc();
      cyc();
      rst_n = 1'b1;
      chk_reset_state();

      single_press_scenario();

      // Three simultaneous presses enter on consecutive edges.
      key_pulse = 5'b10011;
      exp_q.push_back(0);
      exp_q.push_back(1);
      exp_q.push_back(4);
      cyc();
      key_pulse = 5'b00000;
      chk("s2_count1", {28'd0, ev_count}, 32'd1);
      chk("s2_head", {29'd0, ev_code}, 32'd0);
      cyc();
      chk("s2_count2", {28'd0, ev_count}, 32'd2);
      cyc();
      chk("s2_count3", {28'd0, ev_count}, 32'd3);
      cyc();
      chk("s2_count_hold", {28'd0, ev_count}, 32'd3);
      pop_one(5'b00000);
      pop_one(5'b00000);
      pop_one(5'b00000);
      chk("s2_drained", {28'd0, ev_count}, 32'd0);
      chk("s2_ovf", {31'd0, ovf}, 32'd0);

      // Fill to DEPTH, then overrun key 3.
      foreach (seq[i]) begin
         key_pulse = 5'b00001 << seq[i];
         exp_q.push_back(seq[i]);
         cyc();
      end
      key_pulse = 5'b00000;
      chk("s3_full", {28'd0, ev_count}, 32'd8);
      key_pulse = 5'b01000;
      cyc();
      key_pulse = 5'b00000;
      chk("s3_pend3", {27'd0, dut.pend_q}, 32'd8);
      chk("s3_full_hold", {28'd0, ev_count}, 32'd8);
      chk("s3_ovf0", {31'd0, ovf}, 32'd0);
      repeat (4) cyc();
      key_pulse = 5'b01000;
      cyc();
      key_pulse = 5'b00000;
      chk("s3_ovf1", {31'd0, ovf}, 32'd1);
      chk_drop(8'd1);
      chk("s3_pend_kept", {27'd0, dut.pend_q}, 32'd8);
      exp_q.push_back(3);
      pop_one(5'b00000);
      chk("s3_pop_full", {28'd0, ev_count}, 32'd8);
      chk("s3_pend_clear", {27'd0, dut.pend_q}, 32'd0);

      // Full FIFO, pop and key 0 in the same cycle.
      exp_q.push_back(0);
      pop_one(5'b00001);
      chk("s4_count", {28'd0, ev_count}, 32'd8);
      chk("s4_head", {29'd0, ev_code}, exp_q[0]);
      chk("s4_tail", {29'd0, dut.u_fifo.mem_q[dut.u_fifo.wr_ptr_q - 3'd1]}, 32'd0);

      // ovf_clr coinciding with a drop; then clear alone.
      key_pulse = 5'b00100;
      cyc();
      key_pulse = 5'b00100;
      ovf_clr   = 1'b1;
      cyc();
      key_pulse = 5'b00000;
      chk("s5_set_wins", {31'd0, ovf}, 32'd1);
      chk_drop(8'd2);
      cyc();
      ovf_clr = 1'b0;
      chk("s5_cleared", {31'd0, ovf}, 32'd0);
      chk_drop(8'd2);

      // Drain to four entries (first pop admits pending key 2), then queue
      // one more with a second key left pending.
      exp_q.push_back(2);
      pop_one(5'b00000);
      repeat (4) pop_one(5'b00000);
      chk("s6_count4", {28'd0, ev_count}, 32'd4);
      key_pulse = 5'b00011;
      exp_q.push_back(0);
      cyc();
      key_pulse = 5'b00000;
      chk("s6_count5", {28'd0, ev_count}, 32'd5);
      chk("s6_pend", {27'd0, dut.pend_q}, 32'd2);

      // Mid-operation reset with coinciding pulses.
      rst_n     = 1'b0;
      key_pulse = 5'b11111;
      cyc();
      rst_n     = 1'b1;
      key_pulse = 5'b00000;
      chk_reset_state();
      exp_q.delete();
      cyc();
      chk("s6_post_idle", {28'd0, ev_count}, 32'd0);

      single_press_scenario();

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
